prm_edge_scan_seq: RTL and testbench

- Sequencer on the driving side of the PRM obstacle-logic checker interface.
- Sweeps a run of 15-bit configuration codes A..O into a combinational checker, samples the returned edge_mask bit per code, and packs the results LSB-first into 32-bit words.
- Sends the words to the roadmap builder over a valid/ready stream.
- Also counts the number of set mask bits (hits) in the run.

---
 rtl/prm_edge_scan_seq.sv | 156 +++++++++++++++
 tb/tb_prm_edge_scan_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prm_edge_scan_seq.sv
// Scan sequencer for the PRM obstacle-logic checker: sweeps codes into the checker,
// packs the returned edge_mask bits LSB-first into words and streams them out.
module prm_edge_scan_seq #(
    parameter int CODE_W = 15,
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              start,
    input  logic [CODE_W-1:0] code_base,
    input  logic [CNT_W-1:0]  code_count,
    output logic [CODE_W-1:0] chk_code,
    input  logic              chk_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  hit_count,
    output logic [1:0]        fsm_state
);

    // Stream handshake: a word transfers on a rising CLK edge where out_valid && out_ready;
    // out_data/out_last are held stable while out_valid && !out_ready.

    localparam int PTR_W = $clog2(WORD_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state, next_state;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  idx;
    logic [PTR_W-1:0]  ptr;
    logic [WORD_W-1:0] pack;
    logic [WORD_W-1:0] new_word;
    logic              last_code;
    logic              word_done;
    logic              accept;
    logic              stall;
    logic              advance;
    logic              load;

    assign fsm_state = state;

    always_comb begin
        new_word      = pack;
        new_word[ptr] = chk_mask;
        last_code     = (idx == (count_q - CNT_W'(1)));
        word_done     = (ptr == PTR_W'(WORD_W - 1)) || last_code;
        accept        = out_valid && out_ready;
        // A completed word with nowhere to go freezes the sweep on the current code.
        stall         = word_done && out_valid && !out_ready;
        advance       = (state == ISSUE) && !stall;
        load          = advance && word_done;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (code_count == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (advance && last_code) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (accept && out_last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            count_q   <= '0;
            idx       <= '0;
            ptr       <= '0;
            pack      <= '0;
            chk_code  <= '0;
            hit_count <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            done <= (state == DONE);

            if (state == IDLE && start) begin
                count_q   <= code_count;
                idx       <= '0;
                ptr       <= '0;
                pack      <= '0;
                hit_count <= '0;
                busy      <= 1'b1;
                if (code_count != '0) begin
                    chk_code <= code_base;
                end
            end

            if (state == DONE) begin
                busy <= 1'b0;
            end

            if (advance) begin
                idx      <= idx + CNT_W'(1);
                chk_code <= chk_code + CODE_W'(1);
                if (chk_mask && (hit_count != {CNT_W{1'b1}})) begin
                    hit_count <= hit_count + CNT_W'(1);
                end
                if (word_done) begin
                    ptr  <= '0;
                    pack <= '0;
                end else begin
                    ptr  <= ptr + PTR_W'(1);
                    pack <= new_word;
                end
            end

            if (load) begin
                out_data  <= new_word;
                out_last  <= last_code;
                out_valid <= 1'b1;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prm_edge_scan_seq.sv
// Directed bench for prm_edge_scan_seq: a behavioural checker drives chk_mask from
// chk_code, a monitor captures accepted words, and results are compared to hand values.
module tb_prm_edge_scan_seq;

    logic        CLK;
    logic        RST_n;
    logic        start;
    logic [14:0] code_base;
    logic [15:0] code_count;
    logic [14:0] chk_code;
    logic        chk_mask;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [15:0] hit_count;
    logic [1:0]  fsm_state;

    int checks;
    int failures;
    int done_cnt;
    int valid_cnt;
    int mode;

    logic [32:0] exp_q[$];
    logic [32:0] rx_q[$];

    prm_edge_scan_seq dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .start      (start),
        .code_base  (code_base),
        .code_count (code_count),
        .chk_code   (chk_code),
        .chk_mask   (chk_mask),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .hit_count  (hit_count),
        .fsm_state  (fsm_state)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // checker model: 0 -> codes 1 and 3, 1 -> all ones, 2 -> code divisible by 3
    always_comb begin
        chk_mask = 1'b0;
        case (mode)
            0: chk_mask = (chk_code == 15'd1) || (chk_code == 15'd3);
            1: chk_mask = 1'b1;
            2: chk_mask = ((chk_code % 15'd3) == 15'd0);
            default: chk_mask = 1'b0;
        endcase
    end

    // monitor: a word seen valid&&ready at negedge transfers on the next rising edge
    always @(negedge CLK) begin
        if (RST_n && out_valid && out_ready) rx_q.push_back({out_last, out_data});
        if (RST_n && out_valid) valid_cnt++;
        if (RST_n && done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_sb();
        exp_q.delete();
        rx_q.delete();
        done_cnt  = 0;
        valid_cnt = 0;
    endtask

    task automatic start_scan(input logic [14:0] base, input logic [15:0] count);
        @(posedge CLK) #1;
        start      = 1'b1;
        code_base  = base;
        code_count = count;
        @(posedge CLK) #1;
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (done_cnt == 0) check({tag, "_timeout"}, 64'd0, 64'd1);
        repeat (3) @(negedge CLK);
    endtask

    task automatic compare_rx(input string tag);
        int n;
        check({tag, "_nwords"}, 64'(rx_q.size()), 64'(exp_q.size()));
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_word%0d", tag, i), 64'(rx_q[i]), 64'(exp_q[i]));
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        mode       = 0;
        start      = 1'b0;
        code_base  = '0;
        code_count = '0;
        out_ready  = 1'b1;
        RST_n      = 1'b0;
        clear_sb();

        // reset state
        repeat (3) @(negedge CLK);
        check("rst_chk_code", 64'(chk_code), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hit", 64'(hit_count), 64'd0);
        check("rst_state", 64'(fsm_state), 64'd0);
        RST_n = 1'b1;

        // 1: five codes, hits on 1 and 3
        clear_sb();
        mode = 0;
        exp_q.push_back({1'b1, 32'h0000_000A});
        start_scan(15'h0000, 16'd5);
        @(negedge CLK);
        check("t1_busy", 64'(busy), 64'd1);
        wait_done("t1", 200);
        compare_rx("t1");
        check("t1_hit", 64'(hit_count), 64'd2);
        check("t1_done_cnt", 64'(done_cnt), 64'd1);
        check("t1_busy_end", 64'(busy), 64'd0);
        check("t1_chk_hold", 64'(chk_code), 64'h0005);

        // 2: zero-length scan
        clear_sb();
        start_scan(15'h1234, 16'd0);
        @(negedge CLK);
        check("t2_busy_rise", 64'(busy), 64'd1);
        check("t2_done_early", 64'(done), 64'd0);
        @(negedge CLK);
        check("t2_done", 64'(done), 64'd1);
        check("t2_busy_fall", 64'(busy), 64'd0);
        repeat (3) @(negedge CLK);
        check("t2_done_cnt", 64'(done_cnt), 64'd1);
        check("t2_no_valid", 64'(valid_cnt), 64'd0);
        check("t2_hit", 64'(hit_count), 64'd0);
        check("t2_chk_hold", 64'(chk_code), 64'h0005);

        // 3: code wrap across 0x7FFF, all ones, 33 codes
        clear_sb();
        mode = 1;
        exp_q.push_back({1'b0, 32'hFFFF_FFFF});
        exp_q.push_back({1'b1, 32'h0000_0001});
        start_scan(15'h7FF0, 16'd33);
        wait_done("t3", 300);
        compare_rx("t3");
        check("t3_hit", 64'(hit_count), 64'd33);
        check("t3_chk_wrap", 64'(chk_code), 64'h0011);

        // 4: backpressure while word 1 pending and word 2 complete
        clear_sb();
        mode = 2;
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 32'h4924_9249});
        exp_q.push_back({1'b1, 32'h9249_2492});
        start_scan(15'h0000, 16'd64);
        repeat (70) @(negedge CLK);
        check("t4_stall_valid", 64'(out_valid), 64'd1);
        check("t4_stall_chk", 64'(chk_code), 64'h003F);
        check("t4_stall_data", 64'(out_data), 64'h4924_9249);
        repeat (10) @(negedge CLK);
        check("t4_frozen_chk", 64'(chk_code), 64'h003F);
        check("t4_frozen_data", 64'(out_data), 64'h4924_9249);
        check("t4_frozen_last", 64'(out_last), 64'd0);
        check("t4_frozen_hit", 64'(hit_count), 64'd21);
        @(posedge CLK) #1;
        out_ready = 1'b1;
        wait_done("t4", 200);
        compare_rx("t4");
        check("t4_hit", 64'(hit_count), 64'd22);

        // 5: asynchronous reset mid-scan, then a clean short scan
        clear_sb();
        mode = 1;
        start_scan(15'h0000, 16'd40);
        for (int n = 0; n < 100 && chk_code != 15'd17; n++) @(negedge CLK);
        check("t5_reached_17", 64'(chk_code), 64'd17);
        @(posedge CLK) #3;
        RST_n = 1'b0;
        #1;
        check("t5_arst_chk", 64'(chk_code), 64'd0);
        check("t5_arst_busy", 64'(busy), 64'd0);
        check("t5_arst_hit", 64'(hit_count), 64'd0);
        check("t5_arst_valid", 64'(out_valid), 64'd0);
        check("t5_arst_state", 64'(fsm_state), 64'd0);
        repeat (2) @(negedge CLK);
        RST_n = 1'b1;
        clear_sb();
        exp_q.push_back({1'b1, 32'h0000_0007});
        start_scan(15'h0100, 16'd3);
        wait_done("t5", 200);
        compare_rx("t5");
        check("t5_hit", 64'(hit_count), 64'd3);
        check("t5_chk_end", 64'(chk_code), 64'h0103);

        // 6: start during ISSUE is ignored
        clear_sb();
        mode = 0;
        exp_q.push_back({1'b1, 32'h0000_000A});
        start_scan(15'h0000, 16'd5);
        @(posedge CLK) #1;
        start      = 1'b1;
        code_base  = 15'h0200;
        code_count = 16'd9;
        @(posedge CLK) #1;
        start      = 1'b0;
        wait_done("t6", 200);
        compare_rx("t6");
        check("t6_hit", 64'(hit_count), 64'd2);
        check("t6_done_cnt", 64'(done_cnt), 64'd1);
        check("t6_chk_end", 64'(chk_code), 64'h0005);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
